// File: rtl/jacobi_feedback.sv
// Return path of the Jacobi eigen-decomposition loop: captures each rotated
// 3x3 upper triangle, feeds it back as e*, counts iterations and flags completion.
module jacobi_feedback #(
    parameter int WIDTH    = 21,
    parameter int MAX_ITER = 6,
    parameter int TOL      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] r1,
    input  logic signed [WIDTH-1:0] r2,
    input  logic signed [WIDTH-1:0] r3,
    input  logic signed [WIDTH-1:0] r5,
    input  logic signed [WIDTH-1:0] r6,
    input  logic signed [WIDTH-1:0] r9,
    output logic                    in_ready,
    output logic signed [WIDTH-1:0] e1,
    output logic signed [WIDTH-1:0] e2,
    output logic signed [WIDTH-1:0] e3,
    output logic signed [WIDTH-1:0] e5,
    output logic signed [WIDTH-1:0] e6,
    output logic signed [WIDTH-1:0] e9,
    output logic                    e_valid,
    output logic [2:0]              iteration_cnt,
    output logic                    done,
    output logic                    converged
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] TOL_V = WIDTH'(TOL);
    localparam logic [2:0]       MAX_V = 3'(MAX_ITER);

    state_t                  state_r;
    state_t                  state_s;
    logic signed [WIDTH-1:0] e1_r, e2_r, e3_r, e5_r, e6_r, e9_r;
    logic                    e_valid_r;
    logic [2:0]              cnt_r;
    logic                    converged_r;
    logic                    tol_met_s;
    logic                    last_iter_s;

    // Magnitude that saturates the most negative code instead of wrapping.
    function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] res;
        if (x == $signed({1'b1, {(WIDTH-1){1'b0}}})) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (x[WIDTH-1]) begin
            res = $unsigned(-x);
        end else begin
            res = $unsigned(x);
        end
        return res;
    endfunction

    assign tol_met_s   = (abs_sat(e2_r) <= TOL_V) && (abs_sat(e3_r) <= TOL_V) &&
                         (abs_sat(e6_r) <= TOL_V);
    assign last_iter_s = ((cnt_r + 3'd1) == MAX_V);

    // Next-state decode; start overrides everything else.
    always_comb begin
        state_s = state_r;
        if (start) begin
            state_s = ST_WAIT;
        end else begin
            case (state_r)
                ST_IDLE:  state_s = ST_IDLE;
                ST_WAIT:  state_s = in_valid ? ST_CHECK : ST_WAIT;
                ST_CHECK: state_s = (tol_met_s || last_iter_s) ? ST_DONE : ST_WAIT;
                ST_DONE:  state_s = ST_DONE;
                default:  state_s = ST_IDLE;
            endcase
        end
    end

    // State, feedback matrix, iteration counter and verdict registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            e1_r        <= '0;
            e2_r        <= '0;
            e3_r        <= '0;
            e5_r        <= '0;
            e6_r        <= '0;
            e9_r        <= '0;
            e_valid_r   <= 1'b0;
            cnt_r       <= 3'd0;
            converged_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start) begin
                e_valid_r   <= 1'b0;
                cnt_r       <= 3'd0;
                converged_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_WAIT: begin
                        if (in_valid) begin
                            e1_r      <= r1;
                            e2_r      <= r2;
                            e3_r      <= r3;
                            e5_r      <= r5;
                            e6_r      <= r6;
                            e9_r      <= r9;
                            e_valid_r <= 1'b1;
                        end
                    end
                    ST_CHECK: begin
                        // Guard keeps the count pinned at the budget.
                        if (cnt_r != MAX_V) begin
                            cnt_r <= cnt_r + 3'd1;
                        end
                        converged_r <= tol_met_s;
                    end
                    default: begin
                        cnt_r <= cnt_r;
                    end
                endcase
            end
        end
    end

    assign in_ready      = (state_r == ST_WAIT);
    assign done          = (state_r == ST_DONE);
    assign e1            = e1_r;
    assign e2            = e2_r;
    assign e3            = e3_r;
    assign e5            = e5_r;
    assign e6            = e6_r;
    assign e9            = e9_r;
    assign e_valid       = e_valid_r;
    assign iteration_cnt = cnt_r;
    assign converged     = converged_r;

endmodule

// File: tb/tb_jacobi_feedback.sv
// Directed bench for jacobi_feedback with hand-computed expectations.
module tb_jacobi_feedback;

    logic               clk = 1'b0;
    logic               rst, start, in_valid;
    logic signed [20:0] r1, r2, r3, r5, r6, r9;
    logic               in_ready, e_valid, done, converged;
    logic signed [20:0] e1, e2, e3, e5, e6, e9;
    logic [2:0]         iteration_cnt;
    int                 n_cmp = 0;
    int                 n_err = 0;

    jacobi_feedback #(.WIDTH(21), .MAX_ITER(6), .TOL(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .r1(r1), .r2(r2), .r3(r3), .r5(r5), .r6(r6), .r9(r9),
        .in_ready(in_ready),
        .e1(e1), .e2(e2), .e3(e3), .e5(e5), .e6(e6), .e9(e9),
        .e_valid(e_valid), .iteration_cnt(iteration_cnt),
        .done(done), .converged(converged)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_r(input int a1, input int a2, input int a3,
                         input int a5, input int a6, input int a9);
        r1 = 21'(a1); r2 = 21'(a2); r3 = 21'(a3);
        r5 = 21'(a5); r6 = 21'(a6); r9 = 21'(a9);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One handshake plus the CHECK cycle.
    task automatic capture(input int a1, input int a2, input int a3,
                           input int a5, input int a6, input int a9);
        set_r(a1, a2, a3, a5, a6, a9);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        set_r(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_e_valid", e_valid, 0);
        check_eq("rst_cnt", iteration_cnt, 0);

        // In IDLE in_valid must be ignored.
        set_r(9, 9, 9, 9, 9, 9);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("idle_no_capture_e1", e1, 0);
        check_eq("idle_e_valid", e_valid, 0);

        // Single-iteration convergence.
        do_start();
        check_eq("start_in_ready", in_ready, 1);
        set_r(1000, 3, -16, 500, 0, 250);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("conv_T_e_valid", e_valid, 1);
        check_eq("conv_T_in_ready", in_ready, 0);
        check_eq("conv_T_e3", e3, -16);
        tick();
        check_eq("conv_done", done, 1);
        check_eq("conv_converged", converged, 1);
        check_eq("conv_cnt", iteration_cnt, 1);
        check_eq("conv_e9", e9, 250);
        set_r(7, 7, 7, 7, 7, 7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("done_hold_e1", e1, 1000);
        check_eq("done_hold_done", done, 1);

        // Saturated magnitude is not within tolerance.
        do_start();
        check_eq("start_clears_done", done, 0);
        check_eq("start_clears_e_valid", e_valid, 0);
        capture(0, 0, 0, 0, -1048576, 0);
        check_eq("sat_cnt", iteration_cnt, 1);
        check_eq("sat_in_ready", in_ready, 1);
        check_eq("sat_done", done, 0);
        capture(0, 0, 0, 0, 17, 0);
        check_eq("tol17_done", done, 0);
        check_eq("tol17_cnt", iteration_cnt, 2);
        capture(0, 16, -16, 0, 16, 0);
        check_eq("tol16_done", done, 1);
        check_eq("tol16_converged", converged, 1);
        check_eq("tol16_cnt", iteration_cnt, 3);

        // Back-to-back stall into budget exhaustion.
        do_start();
        set_r(1, 100, 0, 2, 0, 3);
        in_valid = 1'b1;
        for (int j = 1; j <= 12; j++) begin
            tick();
            check_eq($sformatf("b2b_in_ready_%0d", j), in_ready,
                     ((j % 2 == 0) && (j < 12)) ? 1 : 0);
            check_eq($sformatf("b2b_cnt_%0d", j), iteration_cnt, j / 2);
        end
        check_eq("budget_done", done, 1);
        check_eq("budget_converged", converged, 0);
        check_eq("budget_e2", e2, 100);
        r2 = 21'sd50;
        tick();
        in_valid = 1'b0;
        check_eq("budget_7th_e2", e2, 100);
        check_eq("budget_7th_in_ready", in_ready, 0);
        check_eq("budget_7th_cnt", iteration_cnt, 6);

        // Restart collides with a handshake.
        do_start();
        capture(5, 100, 0, 0, 0, 0);
        capture(5, 100, 0, 0, 0, 0);
        check_eq("pre_collide_cnt", iteration_cnt, 2);
        set_r(777, 100, 0, 0, 0, 0);
        in_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        check_eq("collide_cnt", iteration_cnt, 0);
        check_eq("collide_e_valid", e_valid, 0);
        check_eq("collide_in_ready", in_ready, 1);
        check_eq("collide_e1", e1, 5);

        // Reset while in CHECK with a count of 3.
        capture(1, 100, 0, 0, 0, 0);
        capture(1, 100, 0, 0, 0, 0);
        capture(1, 100, 0, 0, 0, 0);
        set_r(4, 100, 0, 0, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("mid_cnt", iteration_cnt, 3);
        check_eq("mid_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_cnt", iteration_cnt, 0);
        check_eq("mid_rst_e1", e1, 0);
        check_eq("mid_rst_e2", e2, 0);
        check_eq("mid_rst_e_valid", e_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        check_eq("mid_rst_done", done, 0);
        set_r(8, 8, 8, 8, 8, 8);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_eq("post_rst_no_capture", e1, 0);
        check_eq("post_rst_e_valid", e_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/jacobi_feedback.md
# jacobi_feedback

Return-path block for the Jacobi eigen-decomposition loop of the OBB engine. It accepts each rotated symmetric 3x3 covariance result (upper triangle: elements 1,2,3,5,6,9) from the rotation datapath over a valid/ready handshake. It registers the result as the `e*` feedback operands for the input selector and counts iterations. It declares the decomposition finished when every off-diagonal magnitude is within tolerance or the iteration budget is exhausted.

## Interface
- `WIDTH`, 21: signed element width (two's complement).
- `MAX_ITER`, 6: iteration budget; legal range 1..7.
- `TOL`, 16: off-diagonal tolerance; unsigned, compared against |e2|, |e3|, |e6|.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new decomposition; accepted in any state.
- `in_valid`  in  1  rotation datapath has a result on `r*`.
- `r1`, `r2`, `r3`, `r5`, `r6`, `r9`  in  WIDTH each  signed rotated matrix elements.
- `in_ready`  out  1  block can capture `r*` this cycle.
- `e1`, `e2`, `e3`, `e5`, `e6`, `e9`  out  WIDTH each  registered feedback matrix.
- `e_valid`  out  1  `e*` holds a result of the current decomposition.
- `iteration_cnt`  out  3  completed iterations of the current decomposition.
- `done`  out  1  decomposition finished; held until `start` or `rst`.
- `converged`  out  1  valid while `done`=1; 1 = tolerance met, 0 = budget exhausted.

## Operation
- States: IDLE, WAIT, CHECK, DONE.
- **Reset:**
  - State returns to IDLE.
  - All outputs are 0: `e*`, `e_valid`, `iteration_cnt`, `in_ready`, `done`, `converged`.
- **IDLE:**
  - `in_ready`=0; `in_valid` is ignored.
  - `start` moves the block to WAIT.
- **WAIT:**
  - `in_ready`=1.
  - When `in_valid`=1, `r*` is captured into `e*`, `e_valid` is set, and the block moves to CHECK.
- **CHECK** (exactly one cycle):
  - `in_ready`=0.
  - `iteration_cnt` increments by 1.
  - Tolerance condition: |e2|<=TOL, |e3|<=TOL and |e6|<=TOL.
  - Absolute value saturates: |-2^(WIDTH-1)| = 2^(WIDTH-1)-1. It is computed WIDTH bits wide, with no overflow wrap.
  - Tolerance met: move to DONE with `converged`=1.
  - Tolerance not met and `iteration_cnt`+1 == MAX_ITER: move to DONE with `converged`=0.
  - Otherwise: return to WAIT.
- **DONE:**
  - `done`=1 and `in_ready`=0.
  - `e*`, `e_valid`, `iteration_cnt` and `converged` are held.
  - `in_valid` is ignored.
- **`start` in any state:**
  - `e_valid`, `iteration_cnt`, `done` and `converged` clear to 0.
  - The block moves to WAIT.
  - `e*` keeps its old values but is not valid (`e_valid`=0).
- **Priority:**
  - `rst` > `start` > handshake.
  - If `start` and `in_valid` occur in the same WAIT cycle, the data is dropped and no capture occurs.
- `iteration_cnt` never exceeds MAX_ITER; it does not wrap.
- A diagonal-only input (all off-diagonals zero) converges on the first iteration.

## Timing
- Handshake occurs on edge T (`in_valid`&`in_ready` sampled high).
  - `e*` and `e_valid` update at T.
  - `in_ready` falls at T.
- Edge T+1 (end of CHECK):
  - `iteration_cnt` updates.
  - Either `in_ready` returns to 1, or `done`/`converged` rise.
- Minimum spacing between accepted results: 2 cycles.
- The input selector therefore sees `iteration_cnt`!=0 together with valid `e*` no later than the cycle after the capture.
- `start` to `in_ready`=1: 1 cycle (registered).
- All outputs are registered; there are no combinational input-to-output paths. `in_ready` is a decode of registered state.

## Test plan
- **Reset mid-operation:**
  - Stimulus: assert `rst` while in CHECK with `iteration_cnt`=3.
  - Required: all outputs are 0 on the next cycle and the state is IDLE. A following `in_valid`=1 without `start` produces no capture.
- **Single-iteration convergence:**
  - Stimulus: `start`, then r1=1000, r5=500, r9=250, r2=3, r3=-16, r6=0.
  - Required: `done`=1, `converged`=1 and `iteration_cnt`=1 at T+1; e3=-16.
- **Budget exhaustion:**
  - Stimulus: MAX_ITER=6, with r2=100 on every handshake.
  - Required: six captures are accepted. After the sixth, `done`=1, `converged`=0 and `iteration_cnt`=6. A seventh `in_valid` is not captured and `in_ready` stays 0.
- **Saturation:**
  - Stimulus: r6 = -2^20 (0x100000).
  - Required: |r6| is treated as 2^20-1, so the result is not converged. `iteration_cnt` increments and `in_ready` returns to 1.
- **Back-to-back stall:**
  - Stimulus: hold `in_valid`=1 continuously with non-converging data.
  - Required: captures occur every 2nd cycle, and `in_ready` alternates 1,0,1,0 until DONE.
- **Restart collision:**
  - Stimulus: in WAIT with `iteration_cnt`=2, pulse `start` in the same cycle as `in_valid`=1.
  - Required: no capture, `iteration_cnt`=0, `e_valid`=0, and `in_ready`=1 on the next cycle.
